// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: per-source 2-deep write-back buffers, round-robin grant
// onto N_WPORTS registered register-file write ports, no same-address pairs.
module regfile_wb_arb #(
  parameter  int WIDTH    = 32,
  parameter  int N_REG    = 32,
  parameter  int N_SRC    = 4,
  parameter  int N_WPORTS = 1,
  localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_SRC-1:0]               src_valid,
  output logic [N_SRC-1:0]               src_ready,
  input  logic [N_SRC-1:0][AW-1:0]       src_addr,
  input  logic [N_SRC-1:0][WIDTH-1:0]    src_data,
  output logic [N_WPORTS-1:0]            wen,
  output logic [N_WPORTS-1:0][AW-1:0]    waddr,
  output logic [N_WPORTS-1:0][WIDTH-1:0] wdata,
  output logic                           busy
);

  logic [1:0]       r_cnt  [N_SRC];
  logic [AW-1:0]    r_addr [N_SRC][2];
  logic [WIDTH-1:0] r_data [N_SRC][2];
  logic [N_SRC-1:0] r_ready;
  logic [SW-1:0]    r_rr;
  logic             r_busy;

  logic [N_WPORTS-1:0]            r_wen;
  logic [N_WPORTS-1:0][AW-1:0]    r_waddr;
  logic [N_WPORTS-1:0][WIDTH-1:0] r_wdata;

  logic [N_SRC-1:0]               w_gnt;
  logic [N_WPORTS-1:0]            w_pv;
  logic [N_WPORTS-1:0][AW-1:0]    w_pa;
  logic [N_WPORTS-1:0][WIDTH-1:0] w_pd;
  logic [SW-1:0]                  w_rr_nxt;
  logic                           w_hit;
  int                             w_n;

  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_widx;
  logic [1:0]       w_cnt_nxt [N_SRC];
  logic             w_busy_nxt;

  // Scan heads from r_rr, granting in order and skipping address clashes
  always_comb begin
    w_gnt    = '0;
    w_pv     = '0;
    w_pa     = '0;
    w_pd     = '0;
    w_rr_nxt = r_rr;
    w_hit    = 1'b0;
    w_n      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int s = 0; s < N_SRC; s++) begin
        if ((int'(r_rr) + i) % N_SRC == s) begin
          w_hit = 1'b0;
          for (int k = 0; k < N_WPORTS; k++) begin
            if (k < w_n && w_pa[k] == r_addr[s][0]) w_hit = 1'b1;
          end
          if (r_cnt[s] != 2'd0 && w_n < N_WPORTS && !w_hit) begin
            w_gnt[s] = 1'b1;
            for (int k = 0; k < N_WPORTS; k++) begin
              if (k == w_n) begin
                w_pv[k] = 1'b1;
                w_pa[k] = r_addr[s][0];
                w_pd[k] = r_data[s][0];
              end
            end
            w_n      = w_n + 1;
            w_rr_nxt = SW'((s + 1) % N_SRC);
          end
        end
      end
    end
  end

  // Buffer bookkeeping: push slot, next occupancy, next busy
  always_comb begin
    w_busy_nxt = |w_gnt;
    for (int s = 0; s < N_SRC; s++) begin
      w_push[s]    = src_valid[s] & r_ready[s];
      w_cnt_nxt[s] = r_cnt[s] + {1'b0, w_push[s]} - {1'b0, w_gnt[s]};
      w_widx[s]    = (r_cnt[s] == 2'd2) |
                     ((r_cnt[s] == 2'd1) & ~w_gnt[s]);
      if (w_cnt_nxt[s] != 2'd0) w_busy_nxt = 1'b1;
    end
  end

  // Per-source FIFO storage; head lives in slot 0 and shifts on pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SRC; s++) begin
        r_cnt[s]     <= 2'd0;
        r_addr[s][0] <= '0;
        r_addr[s][1] <= '0;
        r_data[s][0] <= '0;
        r_data[s][1] <= '0;
      end
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        r_cnt[s] <= w_cnt_nxt[s];
        if (w_gnt[s]) begin
          r_addr[s][0] <= r_addr[s][1];
          r_data[s][0] <= r_data[s][1];
        end
        if (w_push[s]) begin
          if (w_widx[s]) begin
            r_addr[s][1] <= src_addr[s];
            r_data[s][1] <= src_data[s];
          end else begin
            r_addr[s][0] <= src_addr[s];
            r_data[s][0] <= src_data[s];
          end
        end
      end
    end
  end

  // Registered ready, busy and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= '0;
      r_busy  <= 1'b0;
      r_rr    <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        r_ready[s] <= (w_cnt_nxt[s] != 2'd2);
      end
      r_busy <= w_busy_nxt;
      r_rr   <= w_rr_nxt;
    end
  end

  // Write ports: pulse wen on grant, hold addr/data otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_pv;
      for (int p = 0; p < N_WPORTS; p++) begin
        if (w_pv[p]) begin
          r_waddr[p] <= w_pa[p];
          r_wdata[p] <= w_pd[p];
        end
      end
    end
  end

  assign src_ready = r_ready;
  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign busy      = r_busy;

endmodule
